// File: rtl/hd_elastic_receiver.sv
// hd_elastic_receiver: elastic receive buffer with zero-latency pass-through.
// Ports:
//   clk, rst (sync, active-low)
//   pipe_data/pipe_valid/ready_output : upstream handshake
//   data_dest/dest_valid/ready        : downstream handshake
//   flush                             : discard all buffered entries
//   count/almost_full/high_water      : registered occupancy status
module hd_elastic_receiver #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int AFULL_LVL  = DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   pipe_data,
    input  logic                    pipe_valid,
    output logic                    ready_output,
    input  logic                    ready,
    output logic [DATA_WIDTH-1:0]   data_dest,
    output logic                    dest_valid,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  high_water
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    // Storage is never reset; only control state is.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] high_water_q, high_water_d;
    logic          almost_full_q, almost_full_d;

    logic empty;
    logic push;
    logic pop;
    logic store;
    logic bpop;

    assign empty = (count_q == '0);

    // ready_output depends only on registered count and flush,
    // never on downstream ready.
    assign ready_output = (count_q < DEPTH_C) & ~flush;

    always_comb begin
        dest_valid = 1'b0;
        data_dest  = pipe_data;
        if (!flush) begin
            if (empty) begin
                dest_valid = pipe_valid;
                data_dest  = pipe_data;
            end else begin
                dest_valid = 1'b1;
                data_dest  = mem_q[rd_ptr_q];
            end
        end else if (!empty) begin
            data_dest = mem_q[rd_ptr_q];
        end
    end

    assign push = pipe_valid & ready_output;
    assign pop  = dest_valid & ready;

    // A pass-through word consumed in the same cycle skips the buffer.
    assign store = push & ~(empty & ready);
    assign bpop  = pop & ~empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + PONE_C;
            end
            if (bpop) begin
                rd_ptr_d = rd_ptr_q + PONE_C;
            end
            unique case ({store, bpop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        high_water_d = high_water_q;
        if (flush) begin
            high_water_d = '0;
        end else if (count_d > high_water_q) begin
            high_water_d = count_d;
        end
    end

    // Registered so it tracks the registered count exactly.
    assign almost_full_d = (count_d >= AFULL_C);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            high_water_q  <= '0;
            almost_full_q <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            high_water_q  <= high_water_d;
            almost_full_q <= almost_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= pipe_data;
        end
    end

    assign count       = count_q;
    assign almost_full = almost_full_q;
    assign high_water  = high_water_q;

endmodule

// File: doc/hd_elastic_receiver.md
HD_ELASTIC_RECEIVER -- requirements
Module: hd_elastic_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, buffer entries; legal values are powers of two, 2..256.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-1, occupancy at or above which almost_full asserts.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port pipe_data  input  DATA_WIDTH  upstream payload.
REQ-007 SHALL have port pipe_valid  input  1  upstream payload valid.
REQ-008 SHALL have port ready_output  output  1  ready returned to upstream.
REQ-009 SHALL have port ready  input  1  downstream ready.
REQ-010 SHALL have port data_dest  output  DATA_WIDTH  payload presented downstream.
REQ-011 SHALL have port dest_valid  output  1  data_dest valid.
REQ-012 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-013 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port almost_full  output  1  count >= AFULL_LVL.
REQ-015 SHALL have port high_water  output  clog2(DEPTH)+1  peak occupancy since reset or flush.

Function
REQ-016 SHALL define push = pipe_valid & ready_output and pop = dest_valid & ready.
REQ-017 SHALL drive ready_output = (count < DEPTH) & ~flush; no combinational path from ready to ready_output.
REQ-018 SHALL, when count == 0, pass through: dest_valid = pipe_valid, data_dest = pipe_data, zero-cycle latency.
REQ-019 SHALL, when count > 0, present the oldest entry: dest_valid = 1, data_dest = mem[rd_ptr].
REQ-020 SHALL store the incoming word when push and not (count == 0 and ready), i.e. a pass-through word accepted downstream in the same cycle is not buffered.
REQ-021 SHALL advance rd_ptr on pop when count > 0; pointers wrap modulo DEPTH.
REQ-022 SHALL update count: +1 on store without buffered pop, -1 on buffered pop without store, unchanged on both or neither.
REQ-023 SHALL preserve strict FIFO order; no word is duplicated or lost except by flush.
REQ-024 SHALL, on flush, set count, rd_ptr, wr_ptr, high_water to 0 next cycle; flush overrides push and pop that cycle.
REQ-025 SHALL force dest_valid = 0 while flush is high.
REQ-026 SHALL update high_water to max(high_water, next count) every cycle.
REQ-027 SHALL register count, almost_full and high_water as state; almost_full is derived from registered count.
REQ-028 SHALL keep data_dest stable while dest_valid & ~ready when count > 0.
REQ-029 SHALL NOT reset the storage array contents; only control state is reset.

Reset
REQ-030 SHALL, while rst == 0 at a clock edge, set count = 0, pointers = 0, high_water = 0, almost_full = 0.
REQ-031 SHALL, during and after reset with count = 0, give ready_output = 1 and dest_valid = pipe_valid (pass-through).
REQ-032 SHALL, on reset mid-operation, discard all buffered entries identically to flush.

Verification
REQ-033 SHALL cover pass-through: count 0, ready = 1, pipe_valid = 1, pipe_data = 0xA5 -> data_dest = 0xA5, dest_valid = 1 same cycle, count stays 0.
REQ-034 SHALL cover fill: DEPTH = 4, ready = 0, push 0x1..0x4 -> count = 4, ready_output = 0, almost_full = 1 from count 3, high_water = 4.
REQ-035 SHALL cover drain order: from full, ready = 1 -> data_dest 0x1, 0x2, 0x3, 0x4 on consecutive cycles, then pass-through.
REQ-036 SHALL cover simultaneous push and pop at count 2 -> count stays 2, order preserved across pointer wrap.
REQ-037 SHALL cover flush at count 3 with pipe_valid = 1 -> ready_output = 0 and dest_valid = 0 that cycle, next cycle count = 0, high_water = 0, flushed words never appear.
REQ-038 SHALL cover random valid/ready stress against a reference queue model, checking ordering, count and high_water every cycle.
